oup_ulpi_regaccess: RTL and testbench
=====================================

Name: oup_ulpi_regaccess

Overview:
Link-side ULPI register access engine, the initiator of the PHY register read/write protocol.
- Accepts single-register requests from link control logic.
- Issues the ULPI TX CMD, with the extended-address byte when needed, then the data and STP for writes, or the bus turnaround and data capture for reads.
- Reports completion or error to the requester.
- Sits between the link core and the ULPI pins, sharing the bus with the receive path.

Parameters:
TIMEOUT_CYCLES, 64, max cycles spent waiting for nxt or dir in any wait state before abort with error (≥2)
CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width

Ports:
clk_i  input  1  ULPI 60 MHz clock, all logic on rising edge
rst_ni  input  1  asynchronous active-low reset
req_i  input  1  request strobe; sampled only in IDLE
we_i  input  1  1=register write, 0=register read
addr_i  input  8  register address
wdata_i  input  8  write data
busy_o  output  1  request in progress
ack_o  output  1  one-cycle completion pulse
err_o  output  1  valid with ack_o; 1=aborted
rdata_o  output  8  read data; valid with ack_o when !we && !err
ulpi_data_i  input  8  ULPI data from PHY
ulpi_data_o  output  8  ULPI data to PHY
ulpi_dir_i  input  1  PHY bus ownership
ulpi_stp_o  output  1  link stop
ulpi_nxt_i  input  1  PHY throttle/accept

Behaviour:
- Reset values: busy_o=0, ack_o=0, err_o=0, rdata_o=8'h00, ulpi_data_o=8'h00, ulpi_stp_o=0, state=IDLE, counter=0.
- Extended addressing: used when addr_i>8'h3F or addr_i==8'h2F.
- Command byte:
  - Write: {2'b10, ext ? 6'b101111 : addr[5:0]}.
  - Read: {2'b11, same low six bits}.
- Request capture:
  - In IDLE with req_i=1 and ulpi_dir_i=0: latch we/addr/wdata, enter CMD, busy_o=1 from the next cycle.
  - req_i while busy or while dir=1 is ignored; the requester holds req_i.
- FSM states (registered outputs):
  - IDLE: drive 8'h00.
  - CMD: drive the command byte, held stable until nxt.
    - nxt=1 → EXTADDR if ext, else WDATA (write) or RTURN (read).
  - EXTADDR: drive addr. nxt=1 → WDATA or RTURN.
  - WDATA: drive wdata. nxt=1 → STP.
  - STP: ulpi_stp_o=1 for exactly one cycle, data 8'h00; then IDLE with ack_o=1, err_o=0.
  - RTURN: drive 8'h00. dir=1 → RDATA (that cycle is turnaround; data ignored).
  - RDATA: capture ulpi_data_i into rdata_o.
    - nxt=0 → RWAIT.
    - nxt=1 (PHY overrode with USB receive) → ABORT.
  - RWAIT: wait for dir=0 (turnaround back); then IDLE with ack_o=1, err_o=0.
  - ABORT: data 8'h00, stp=0; wait for dir=0, then IDLE with ack_o=1, err_o=1.
- Bus contention:
  - dir=1 sampled in CMD, EXTADDR or WDATA before nxt → ABORT; stp is never asserted.
  - dir=1 together with nxt=1 in these states → ABORT as well (dir has priority).
- Drive rule: whenever ulpi_dir_i=1, ulpi_data_o is driven 8'h00.
- Timeout:
  - Counter clears on every state change and increments each cycle in CMD/EXTADDR/WDATA/RTURN/RWAIT.
  - Reaching TIMEOUT_CYCLES → ABORT. If dir=0, ack_o/err_o=1 on the next cycle.
  - Counter saturates, no wrap.
- Completion: ack_o and err_o are single-cycle pulses coinciding with busy_o falling. A new request is accepted no earlier than the cycle after ack_o.
- rdata_o keeps its last captured value until the next successful read.
- Reset mid-operation:
  - All outputs return immediately (asynchronously) to reset values.
  - A write interrupted before STP leaves the PHY register unwritten; no ack is produced.
- Latency (nxt immediate, dir prompt):
  - Immediate write: req → ack in 4 cycles.
  - Extended write: 5 cycles.
  - Immediate read: req → ack in 5 cycles plus PHY turnaround.

Test Plan:
1. Write addr 8'h16 (SCRATCH), data 8'hA5, PHY nxt after 1 cycle → ulpi_data_o sequence 8'h96, 8'hA5, 8'h00 with stp=1 for exactly one cycle; ack_o=1, err_o=0; subsequent read returns 8'hA5.
2. Read addr 8'h00 → cmd 8'hC0; PHY turnaround then 8'hCD; rdata_o=8'hCD, ack_o=1, err_o=0; ulpi_data_o=8'h00 whenever dir=1.
3. Extended write addr 8'h85, data 8'h3C → bytes 8'hAF, 8'h85, 8'h3C, stp pulse; also a write with nxt withheld 3 cycles → command byte held stable, no stp early.
4. PHY asserts dir during CMD (no nxt) → no stp, ABORT; after dir drops, ack_o=1, err_o=1; an immediate retry succeeds.
5. PHY never asserts nxt, TIMEOUT_CYCLES=64 → ack_o=1, err_o=1 after 64 cycles in CMD; busy_o falls the same cycle.
6. rst_ni pulled low mid-WDATA → busy_o, stp, data_o = 0 immediately; no ack; the next request after release completes normally.

Source files
------------

// File: rtl/oup_ulpi_regaccess.sv
// ---------------------------------------------------------------------------
// oup_ulpi_regaccess
//
// Link-side ULPI register access engine. Takes one register read or write
// request at a time from the link core, runs the ULPI register protocol
// (TX CMD, optional extended-address byte, write data + STP, or bus
// turnaround + read data capture) and reports completion or abort.
//
// Ports
//   clk_i, rst_ni        ULPI 60 MHz clock, asynchronous active-low reset
//   req_i                request strobe, only looked at while idle
//   we_i                 1 = register write, 0 = register read
//   addr_i, wdata_i      register address and write data
//   busy_o               request in progress
//   ack_o, err_o         one-cycle completion pulse, err_o=1 on abort
//   rdata_o              last successfully read register value
//   ulpi_data_i/_o       ULPI data bus (PHY -> link / link -> PHY)
//   ulpi_dir_i           PHY owns the bus when high
//   ulpi_stp_o           link stop
//   ulpi_nxt_i           PHY throttle / accept
// ---------------------------------------------------------------------------
module oup_ulpi_regaccess #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_i,
    input  logic       we_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] wdata_i,
    output logic       busy_o,
    output logic       ack_o,
    output logic       err_o,
    output logic [7:0] rdata_o,
    input  logic [7:0] ulpi_data_i,
    output logic [7:0] ulpi_data_o,
    input  logic       ulpi_dir_i,
    output logic       ulpi_stp_o,
    input  logic       ulpi_nxt_i
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_EXTADDR,
        S_WDATA,
        S_STP,
        S_RTURN,
        S_RDATA,
        S_RWAIT,
        S_ABORT
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Addresses that do not fit the 6-bit immediate field, plus the escape
    // code 6'h2F itself, go through the extended-address byte.
    function automatic logic needs_ext(input logic [7:0] a);
        return (a > 8'h3F) || (a == 8'h2F);
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             stp_q, stp_d;
    logic [7:0]       rdata_q, rdata_d;
    logic [7:0]       data_q, data_d;

    logic             waiting;
    logic             timeout;
    logic             done_ok;
    logic             done_err;

    always_comb begin
        // NOTE: every signal written here gets a default first, otherwise a
        // path that skips the assignment would infer a latch.
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        done_ok  = 1'b0;
        done_err = 1'b0;

        waiting = (state_q == S_CMD)   || (state_q == S_EXTADDR) ||
                  (state_q == S_WDATA) || (state_q == S_RTURN)   ||
                  (state_q == S_RWAIT);
        timeout = waiting && (cnt_q >= CNT_LAST);

        case (state_q)
            S_IDLE: begin
                // Blocked during the ack cycle: the requester holds req_i
                // until it sees ack_o, so that cycle must not start a repeat.
                if (req_i && !ulpi_dir_i && !ack_q) begin
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                // dir has priority over nxt: the PHY took the bus back.
                if (ulpi_dir_i)      state_d = S_ABORT;
                else if (ulpi_nxt_i) state_d = needs_ext(addr_q) ? S_EXTADDR
                                             : (we_q ? S_WDATA : S_RTURN);
                else if (timeout)    state_d = S_ABORT;
            end
            S_EXTADDR: begin
                if (ulpi_dir_i)      state_d = S_ABORT;
                else if (ulpi_nxt_i) state_d = we_q ? S_WDATA : S_RTURN;
                else if (timeout)    state_d = S_ABORT;
            end
            S_WDATA: begin
                if (ulpi_dir_i)      state_d = S_ABORT;
                else if (ulpi_nxt_i) state_d = S_STP;
                else if (timeout)    state_d = S_ABORT;
            end
            S_STP: begin
                state_d = S_IDLE;
                done_ok = 1'b1;
            end
            S_RTURN: begin
                // The cycle dir rises is turnaround; data is taken next cycle.
                if (ulpi_dir_i)      state_d = S_RDATA;
                else if (timeout)    state_d = S_ABORT;
            end
            S_RDATA: begin
                // nxt here means the PHY preempted the read with USB receive
                // data; leave rdata untouched.
                if (ulpi_nxt_i) begin
                    state_d = S_ABORT;
                end else begin
                    rdata_d = ulpi_data_i;
                    state_d = S_RWAIT;
                end
            end
            S_RWAIT: begin
                if (!ulpi_dir_i) begin
                    state_d = S_IDLE;
                    done_ok = 1'b1;
                end else if (timeout) begin
                    state_d = S_ABORT;
                end
            end
            S_ABORT: begin
                if (!ulpi_dir_i) begin
                    state_d  = S_IDLE;
                    done_err = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q)              cnt_d = '0;
        else if (waiting && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        else                                  cnt_d = cnt_q;

        // Outputs are registered, so they are derived from the next state.
        busy_d = (state_d != S_IDLE);
        ack_d  = done_ok || done_err;
        err_d  = done_err;
        stp_d  = (state_d == S_STP);
        case (state_d)
            S_CMD:     data_d = {1'b1, ~we_d, needs_ext(addr_d) ? 6'h2F : addr_d[5:0]};
            S_EXTADDR: data_d = addr_d;
            S_WDATA:   data_d = wdata_d;
            default:   data_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            stp_q   <= 1'b0;
            rdata_q <= 8'h00;
            data_q  <= 8'h00;
        end else begin
            // NOTE: state flops use non-blocking assignment so every flop
            // samples the values from before this edge.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            stp_q   <= stp_d;
            rdata_q <= rdata_d;
            data_q  <= data_d;
        end
    end

    assign busy_o     = busy_q;
    assign ack_o      = ack_q;
    assign err_o      = err_q;
    assign rdata_o    = rdata_q;
    assign ulpi_stp_o = stp_q;
    // The PHY owns the bus whenever dir is high, so the link must go quiet
    // in that same cycle rather than one register stage later.
    assign ulpi_data_o = ulpi_dir_i ? 8'h00 : data_q;

endmodule

// File: tb/tb_oup_ulpi_regaccess.sv
// ---------------------------------------------------------------------------
// tb_oup_ulpi_regaccess
//
// Self-checking bench for oup_ulpi_regaccess. The bench plays the PHY: it
// answers the handshake with nxt/dir, latches the bytes it accepts, decodes
// them into its own register file, and returns register contents on reads.
// Expected results come from an address-indexed reference register file and
// from protocol rules (byte sequence, latency formulas).
// ---------------------------------------------------------------------------
module tb_oup_ulpi_regaccess;

    localparam int TIMEOUT = 64;

    logic       clk_i       = 1'b0;
    logic       rst_ni      = 1'b0;
    logic       req_i       = 1'b0;
    logic       we_i        = 1'b0;
    logic [7:0] addr_i      = 8'h00;
    logic [7:0] wdata_i     = 8'h00;
    logic [7:0] ulpi_data_i = 8'h00;
    logic       ulpi_dir_i  = 1'b0;
    logic       ulpi_nxt_i  = 1'b0;
    logic       busy_o;
    logic       ack_o;
    logic       err_o;
    logic [7:0] rdata_o;
    logic [7:0] ulpi_data_o;
    logic       ulpi_stp_o;

    oup_ulpi_regaccess #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .busy_o      (busy_o),
        .ack_o       (ack_o),
        .err_o       (err_o),
        .rdata_o     (rdata_o),
        .ulpi_data_i (ulpi_data_i),
        .ulpi_data_o (ulpi_data_o),
        .ulpi_dir_i  (ulpi_dir_i),
        .ulpi_stp_o  (ulpi_stp_o),
        .ulpi_nxt_i  (ulpi_nxt_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    logic [7:0] ref_regs [256];
    logic [7:0] phy_regs [256];
    logic [7:0] last_rdata;
    logic [7:0] wr_addrs [$];
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic is_ext(input logic [7:0] a);
        return (a > 8'h3F) || (a == 8'h2F);
    endfunction

    function automatic logic [7:0] cmd_of(input logic we, input logic [7:0] a);
        return {(we ? 2'b10 : 2'b11), (is_ext(a) ? 6'h2F : a[5:0])};
    endfunction

    // How a PHY interprets the command byte plus optional extended byte.
    function automatic logic [7:0] phy_addr(input logic [7:0] c, input logic [7:0] e);
        return (c[5:0] == 6'h2F) ? e : {2'b00, c[5:0]};
    endfunction

    function automatic logic [7:0] rand_addr();
        case ($urandom % 4)
            0, 1:    return 8'($urandom % 64);
            2:       return 8'h2F;
            default: return 8'(8'h40 + ($urandom % 192));
        endcase
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after
    // the capture edge with t0 = cycle stamp of the first CMD cycle.
    task automatic issue_req(input logic we, input logic [7:0] a, input logic [7:0] d,
                             output int t0);
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = a;
        wdata_i = d;
        @(negedge clk_i);
        check("busy_rise", 32'(busy_o), 1);
        t0 = cyc;
    endtask

    // PHY withholds nxt for wait_n cycles, then accepts the byte.
    task automatic send_byte(input logic [7:0] exp, input int wait_n, output logic [7:0] seen);
        for (int i = 0; i < wait_n; i++) begin
            check("byte_held", 32'(ulpi_data_o), 32'(exp));
            check("no_early_stp", 32'(ulpi_stp_o), 0);
            @(negedge clk_i);
        end
        check("byte", 32'(ulpi_data_o), 32'(exp));
        check("busy_in_byte", 32'(busy_o), 1);
        seen       = ulpi_data_o;
        ulpi_nxt_i = 1'b1;
        @(negedge clk_i);
        ulpi_nxt_i = 1'b0;
    endtask

    task automatic expect_ack(input logic exp_err);
        check("ack", 32'(ack_o), 1);
        check("err", 32'(err_o), 32'(exp_err));
        check("busy_fall", 32'(busy_o), 0);
        check("stp_idle", 32'(ulpi_stp_o), 0);
        req_i = 1'b0;
        @(negedge clk_i);
        check("ack_pulse", 32'(ack_o), 0);
        check("stay_idle", 32'(busy_o), 0);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d,
                            input int w0, input int w1, input int w2);
        logic [7:0] b0, b1, b2;
        int t0, exp_lat;
        b1 = 8'h00;
        issue_req(1'b1, a, d, t0);
        send_byte(cmd_of(1'b1, a), w0, b0);
        if (is_ext(a)) send_byte(a, w1, b1);
        send_byte(d, w2, b2);
        check("stp", 32'(ulpi_stp_o), 1);
        check("stp_data", 32'(ulpi_data_o), 0);
        check("ack_before_stp", 32'(ack_o), 0);
        if (ulpi_stp_o && b0[7:6] == 2'b10) phy_regs[phy_addr(b0, b1)] = b2;
        @(negedge clk_i);
        exp_lat = (w0 + 1) + (is_ext(a) ? w1 + 1 : 0) + (w2 + 1) + 1;
        check("wr_latency", 32'(cyc - t0), 32'(exp_lat));
        expect_ack(1'b0);
        ref_regs[a] = d;
        wr_addrs.push_back(a);
    endtask

    task automatic do_read(input logic [7:0] a, input int w0, input int w1,
                           input int ta, input int hold, input logic nxt_abort);
        logic [7:0] b0, b1;
        int t0;
        b1 = 8'h00;
        issue_req(1'b0, a, 8'($urandom), t0);
        send_byte(cmd_of(1'b0, a), w0, b0);
        if (is_ext(a)) send_byte(a, w1, b1);
        for (int i = 0; i < ta; i++) begin
            check("rturn_data", 32'(ulpi_data_o), 0);
            check("rturn_busy", 32'(busy_o), 1);
            @(negedge clk_i);
        end
        ulpi_dir_i  = 1'b1;
        ulpi_data_i = 8'($urandom);
        @(negedge clk_i);
        check("dir_quiet", 32'(ulpi_data_o), 0);
        ulpi_data_i = nxt_abort ? 8'($urandom) : phy_regs[phy_addr(b0, b1)];
        ulpi_nxt_i  = nxt_abort;
        @(negedge clk_i);
        ulpi_nxt_i  = 1'b0;
        ulpi_data_i = 8'($urandom);
        if (!nxt_abort) last_rdata = ref_regs[a];
        check("rdata_capture", 32'(rdata_o), 32'(last_rdata));
        for (int i = 0; i < hold; i++) begin
            check("rwait_busy", 32'(busy_o), 1);
            check("rwait_ack", 32'(ack_o), 0);
            check("rwait_data", 32'(ulpi_data_o), 0);
            check("rwait_stp", 32'(ulpi_stp_o), 0);
            @(negedge clk_i);
        end
        ulpi_dir_i = 1'b0;
        @(negedge clk_i);
        check("rdata_at_ack", 32'(rdata_o), 32'(last_rdata));
        expect_ack(nxt_abort);
    endtask

    // PHY grabs the bus (dir=1, nxt random) during byte number 'stage'.
    task automatic do_abort(input logic we, input logic [7:0] a, input logic [7:0] d,
                            input int stage, input int k);
        logic [7:0] bytes [$];
        logic [7:0] tmp;
        int t0;
        bytes.push_back(cmd_of(we, a));
        if (is_ext(a)) bytes.push_back(a);
        if (we) bytes.push_back(d);
        issue_req(we, a, d, t0);
        for (int j = 0; j < stage; j++) send_byte(bytes[j], 0, tmp);
        for (int i = 0; i < k; i++) begin
            check("pre_abort_byte", 32'(ulpi_data_o), 32'(bytes[stage]));
            @(negedge clk_i);
        end
        ulpi_dir_i = 1'b1;
        ulpi_nxt_i = 1'($urandom);
        @(negedge clk_i);
        ulpi_nxt_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("abort_no_stp", 32'(ulpi_stp_o), 0);
            check("abort_data", 32'(ulpi_data_o), 0);
            check("abort_busy", 32'(busy_o), 1);
            check("abort_no_ack", 32'(ack_o), 0);
            @(negedge clk_i);
        end
        ulpi_dir_i = 1'b0;
        @(negedge clk_i);
        check("abort_rdata_kept", 32'(rdata_o), 32'(last_rdata));
        expect_ack(1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0, n_cmd;
        logic done;
        logic [7:0] b0;

        for (int i = 0; i < 256; i++) begin
            ref_regs[i] = 8'($urandom);
            phy_regs[i] = ref_regs[i];
        end
        ref_regs[0] = 8'hCD;
        phy_regs[0] = 8'hCD;
        last_rdata  = 8'h00;

        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_ack", 32'(ack_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_rdata", 32'(rdata_o), 0);
        check("rst_data", 32'(ulpi_data_o), 0);
        check("rst_stp", 32'(ulpi_stp_o), 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Write SCRATCH, read it back; read address 0
        do_write(8'h16, 8'hA5, 1, 0, 1);
        do_read(8'h16, 1, 0, 1, 1, 1'b0);
        do_read(8'h00, 0, 0, 0, 0, 1'b0);

        // Extended write, then a write with nxt withheld 3 cycles per byte
        do_write(8'h85, 8'h3C, 0, 0, 0);
        do_write(8'h2F, 8'h11, 3, 3, 3);
        do_read(8'h85, 0, 2, 2, 2, 1'b0);

        // Request ignored while the PHY owns the bus
        ulpi_dir_i = 1'b1;
        req_i = 1'b1; we_i = 1'b1; addr_i = 8'h05; wdata_i = 8'h42;
        repeat (3) begin
            @(negedge clk_i);
            check("ignore_req_dir", 32'(busy_o), 0);
        end
        req_i = 1'b0;
        ulpi_dir_i = 1'b0;
        @(negedge clk_i);
        check("ignore_req_dir_after", 32'(busy_o), 0);

        // dir during CMD, then immediate retry
        do_abort(1'b1, 8'h0A, 8'h77, 0, 1);
        do_write(8'h0A, 8'h78, 0, 0, 0);
        // read preempted by USB receive
        do_read(8'h0A, 0, 0, 1, 1, 1'b1);

        // Timeout: PHY never answers with nxt
        issue_req(1'b1, 8'h16, 8'h33, t0);
        n_cmd = 0;
        done  = 1'b0;
        for (int i = 0; i < 4 * TIMEOUT && !done; i++) begin
            if (ack_o) begin
                done = 1'b1;
            end else begin
                if (ulpi_data_o == cmd_of(1'b1, 8'h16)) n_cmd++;
                if (ulpi_stp_o) check("to_no_stp", 32'(ulpi_stp_o), 0);
                @(negedge clk_i);
            end
        end
        check("to_ack_seen", 32'(done), 1);
        check("to_cmd_cycles", 32'(n_cmd), 32'(TIMEOUT));
        check("to_latency", 32'(cyc - t0), 32'(TIMEOUT + 1));
        expect_ack(1'b1);
        do_read(8'h16, 0, 0, 0, 0, 1'b0);

        // Reset in the middle of WDATA
        issue_req(1'b1, 8'h20, 8'h99, t0);
        send_byte(cmd_of(1'b1, 8'h20), 0, b0);
        check("wdata_before_rst", 32'(ulpi_data_o), 32'h99);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_busy", 32'(busy_o), 0);
        check("arst_stp", 32'(ulpi_stp_o), 0);
        check("arst_data", 32'(ulpi_data_o), 0);
        check("arst_ack", 32'(ack_o), 0);
        check("arst_rdata", 32'(rdata_o), 0);
        last_rdata = 8'h00;
        req_i = 1'b0;
        @(negedge clk_i);
        check("arst_hold_ack", 32'(ack_o), 0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("post_rst_ack", 32'(ack_o), 0);
        check("post_rst_busy", 32'(busy_o), 0);
        do_read(8'h20, 0, 0, 1, 0, 1'b0);
        do_write(8'h20, 8'h5E, 1, 0, 2);
        do_read(8'h20, 0, 0, 0, 1, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            logic [7:0] a;
            int sel;
            a   = rand_addr();
            sel = int'($urandom % 20);
            if (sel < 2) begin
                logic we;
                we = 1'($urandom);
                do_abort(we, a, 8'($urandom),
                         int'($urandom % (1 + (is_ext(a) ? 1 : 0) + (we ? 1 : 0))),
                         int'($urandom % 4));
            end else if (sel < 4) begin
                do_read(a, int'($urandom % 3), int'($urandom % 3), int'($urandom % 3),
                        int'($urandom % 3), 1'b1);
            end else if (sel % 2 == 1) begin
                do_write(a, 8'($urandom), int'($urandom % 4), int'($urandom % 4),
                         int'($urandom % 4));
            end else begin
                do_read(a, int'($urandom % 3), int'($urandom % 3), int'($urandom % 3),
                        int'($urandom % 3), 1'b0);
            end
        end

        // Read back the most recent writes
        while (wr_addrs.size() > 0) begin
            logic [7:0] a;
            a = wr_addrs.pop_back();
            if (wr_addrs.size() < 4) do_read(a, 0, 0, 1, 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
